beat_generator: RTL and testbench

BEAT_GENERATOR -- requirements
Module: beat_generator

---
 rtl/beat_generator.sv | 112 +++++++++++
 tb/tb_beat_generator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/beat_generator.sv
// Metronome beat generator: DDA phase accumulator, registered outputs one clock after inputs, no backpressure.
// Bar counter, beat_index and accent exist only when BEAT_GENERATOR_ACCENT_EN is defined (otherwise tied 0).
module beat_generator #(
  parameter int CLK_HZ        = 50000000,
  parameter int BEATS_PER_BAR = 4,
  parameter int PULSE_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] BPM,
  output logic       beat,
  output logic       accent,
  output logic       beat_led,
  output logic [2:0] beat_index
);

  localparam longint unsigned THRESH_L = 64'(CLK_HZ) * 64'd60;
  // Accumulator must hold THRESH-1+255 without wrapping.
  localparam int ACC_W = $clog2(THRESH_L + 64'd256);
  localparam logic [ACC_W-1:0] THRESH = ACC_W'(THRESH_L);
  localparam int LED_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [LED_W-1:0] PULSE_LOAD = LED_W'(PULSE_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n, sum;
  logic               beat_n;
  logic [LED_W-1:0]   led_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      beat  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      beat  <= beat_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    beat_n  = 1'b0;
    sum     = acc + ACC_W'(BPM);
    case (state)
      IDLE: begin
        if (enable && BPM != 8'd0) begin
          state_n = RUN;
          acc_n   = '0;
          beat_n  = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_n = IDLE;
          acc_n   = '0;
        end else if (BPM != 8'd0) begin
          if (sum >= THRESH) begin
            acc_n  = sum - THRESH;
            beat_n = 1'b1;
          end else begin
            acc_n  = sum;
          end
        end
      end
    endcase
  end

  // Every beat reloads the full on-time, so fast tempos keep the LED lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_cnt  <= '0;
      beat_led <= 1'b0;
    end else if (beat_n) begin
      led_cnt  <= PULSE_LOAD;
      beat_led <= 1'b1;
    end else if (led_cnt != '0) begin
      led_cnt  <= led_cnt - LED_W'(1);
      beat_led <= (led_cnt > LED_W'(1));
    end else begin
      beat_led <= 1'b0;
    end
  end

`ifdef BEAT_GENERATOR_ACCENT_EN
  localparam logic [2:0] LAST_IDX = 3'(BEATS_PER_BAR - 1);

  // A beat seen while idle or stopping is the bar-start beat, so the index restarts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_index <= 3'd0;
      accent     <= 1'b0;
    end else if (state == IDLE || !enable) begin
      beat_index <= 3'd0;
      accent     <= beat_n;
    end else if (beat_n) begin
      beat_index <= (beat_index == LAST_IDX) ? 3'd0 : beat_index + 3'd1;
      accent     <= (beat_index == LAST_IDX);
    end else begin
      accent     <= 1'b0;
    end
  end
`else
  assign beat_index = 3'd0;
  assign accent     = 1'b0;
`endif

endmodule

// File: tb/tb_beat_generator.sv
// Bench for beat_generator: phase-count reference model checked every cycle plus directed tempo scenarios.
module tb_beat_generator;
  localparam int CLK_HZ = 10;
  localparam int BPB    = 4;
  localparam int PULSE  = 3;
  localparam int THRESH = 600;
`ifdef BEAT_GENERATOR_ACCENT_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [7:0] bpm;
  logic       beat, accent, beat_led;
  logic [2:0] beat_index;

  beat_generator #(.CLK_HZ(CLK_HZ), .BEATS_PER_BAR(BPB), .PULSE_CYCLES(PULSE)) dut (
    .clk(clk), .rst(rst), .enable(enable), .BPM(bpm),
    .beat(beat), .accent(accent), .beat_led(beat_led), .beat_index(beat_index)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: total phase since start; a beat happens whenever phase crosses a multiple of THRESH.
  bit     m_run = 0, m_beat = 0, m_has = 0;
  longint m_phase = 0, m_before = 0, m_last = 0;
  int     m_nbeat = 0;

  always @(posedge clk) begin
    cyc++;
    m_beat = 0;
    if (rst) begin
      m_run = 0; m_phase = 0; m_nbeat = 0; m_has = 0;
    end else if (!m_run) begin
      if (enable && bpm != 0) begin
        m_run = 1; m_phase = 0; m_nbeat = 0; m_beat = 1;
      end
    end else if (!enable) begin
      m_run = 0; m_phase = 0; m_nbeat = 0;
    end else begin
      m_before = m_phase / THRESH;
      m_phase  = m_phase + longint'(bpm);
      if (m_phase / THRESH != m_before) begin
        m_beat = 1;
        m_nbeat++;
      end
    end
    if (m_beat) begin
      m_has  = 1;
      m_last = cyc;
    end
  end

  longint bq[$];
  int     aq[$], iq[$];

  always @(negedge clk) begin
    check("model_beat", 64'(beat), 64'(m_beat));
    check("model_accent", 64'(accent), 64'(ACC_EN && m_beat && (m_nbeat % BPB == 0)));
    check("model_index", 64'(beat_index), ACC_EN ? 64'(m_nbeat % BPB) : 64'd0);
    check("model_led", 64'(beat_led), 64'(m_has && (cyc - m_last) < PULSE));
    if (beat === 1'b1) begin
      bq.push_back(cyc);
      aq.push_back(int'(accent));
      iq.push_back(int'(beat_index));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clearq();
    bq.delete(); aq.delete(); iq.delete();
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k = 0;
    while (bq.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(name, 64'(bq.size()), 64'(n));
  endtask

  longint s, d, last_b;
  int     low, nb;
  int     t2_acc[5] = '{1, 0, 0, 0, 1};
  int     t2_idx[5] = '{0, 1, 2, 3, 0};
  int     t4_off[6] = '{1, 11, 19, 24, 29, 34};

  initial begin
    rst = 1'b1; enable = 1'b0; bpm = 8'd0;
    step(2);
    check("rst_beat", 64'(beat), 64'd0);
    check("rst_accent", 64'(accent), 64'd0);
    check("rst_led", 64'(beat_led), 64'd0);
    check("rst_index", 64'(beat_index), 64'd0);

    // 60 BPM: beat on the first edge, then every 10 clocks
    clearq(); rst = 1'b0; enable = 1'b1; bpm = 8'd60; s = cyc;
    step(41);
    check("t60_count", 64'(bq.size()), 64'd5);
    for (int i = 0; i < 5 && i < bq.size(); i++) begin
      check("t60_time", 64'(bq[i]), 64'(s + 1 + 10 * i));
      check("t60_accent", 64'(aq[i]), ACC_EN ? 64'(t2_acc[i]) : 64'd0);
      check("t60_index", 64'(iq[i]), ACC_EN ? 64'(t2_idx[i]) : 64'd0);
    end

    // BPM=0 keeps the block idle; BPM=30 then starts it
    enable = 1'b0; step(3); clearq();
    enable = 1'b1; bpm = 8'd0; step(5);
    check("bpm0_nobeat", 64'(bq.size()), 64'd0);
    check("bpm0_led", 64'(beat_led), 64'd0);
    s = cyc; bpm = 8'd30;
    step(41);
    check("t30_count", 64'(bq.size()), 64'd3);
    for (int i = 0; i < 3 && i < bq.size(); i++)
      check("t30_time", 64'(bq[i]), 64'(s + 1 + 20 * i));

    // Tempo change 60->120 six clocks after a beat keeps the accumulated phase
    enable = 1'b0; step(2); clearq();
    enable = 1'b1; bpm = 8'd60; s = cyc;
    wait_beats(2, 20, "chg_wait");
    step(6); bpm = 8'd120;
    step(20);
    check("chg_count", 64'(bq.size()), 64'd6);
    for (int i = 0; i < 6 && i < bq.size(); i++)
      check("chg_time", 64'(bq[i]), 64'(s + t4_off[i]));

    // BPM=7 over 600 clocks: 7 beats after the start beat, intervals 85 or 86
    enable = 1'b0; step(2); clearq();
    enable = 1'b1; bpm = 8'd7;
    step(601);
    check("t7_count", 64'(bq.size()), 64'd8);
    if (bq.size() > 1) check("t7_first", 64'(bq[1] - bq[0]), 64'd86);
    for (int i = 1; i < bq.size(); i++) begin
      d = bq[i] - bq[i-1];
      check("t7_interval", 64'(d == 85 || d == 86), 64'd1);
    end

    // BPM=255 keeps the LED lit; after stop it finishes its 3-clock pulse
    enable = 1'b0; step(2); clearq();
    enable = 1'b1; bpm = 8'd255;
    step(1);
    low = 0;
    repeat (30) begin
      step(1);
      if (beat_led !== 1'b1) low++;
    end
    check("fast_led_cont", 64'(low), 64'd0);
    enable = 1'b0;
    nb = bq.size();
    last_b = (nb > 0) ? bq[nb-1] : 0;
    low = 0;
    while (beat_led !== 1'b0 && low < 10) begin
      step(1);
      low++;
    end
    check("stop_led_len", 64'(cyc - last_b), 64'd3);
    check("stop_nobeat", 64'(bq.size()), 64'(nb));

    // Reset mid-bar and mid-pulse, with enable held high
    clearq(); enable = 1'b1; bpm = 8'd60;
    wait_beats(2, 20, "mid_wait");
    step(1);
    rst = 1'b1;
    step(1);
    check("mid_rst_beat", 64'(beat), 64'd0);
    check("mid_rst_accent", 64'(accent), 64'd0);
    check("mid_rst_led", 64'(beat_led), 64'd0);
    check("mid_rst_index", 64'(beat_index), 64'd0);
    rst = 1'b0;
    step(1);
    check("restart_beat", 64'(beat), 64'd1);
    check("restart_accent", 64'(accent), 64'(ACC_EN));
    check("restart_index", 64'(beat_index), 64'd0);
    check("restart_led", 64'(beat_led), 64'd1);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
